led_status_encoder: RTL

Output stage between the heartbeat generator and the board status LED. Passes the heartbeat square wave to the LED in healthy operation. When a nonzero fault code is presented, it overrides the heartbeat with a repeating blink-code sequence: N blinks, then a gap. All LED drive is gated by a free-running PWM brightness counter, so one physical LED carries liveness, fault identity and dimming.

---
 rtl/led_status_pkg.sv | 16 +
 rtl/led_status_encoder_if.sv | 26 ++
 rtl/led_pwm_gen.sv | 23 ++
 rtl/led_status_encoder.sv | 110 +++++++++++
 4 files changed

// File: rtl/led_status_pkg.sv
// Shared types and default parameters for the status LED encoder.
package led_status_pkg;

  localparam int unsigned PWM_BITS_DEF  = 8;
  localparam int unsigned BLINK_DIV_DEF = 5000000;
  localparam int unsigned GAP_SLOTS_DEF = 4;
  localparam int unsigned CODE_W_DEF    = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2,
    ST_GAP  = 2'd3
  } led_state_e;

endpackage

// File: rtl/led_status_encoder_if.sv
// Heartbeat/fault/brightness inputs and LED status outputs of the encoder.
interface led_status_encoder_if
  import led_status_pkg::*;
#(
  parameter int unsigned PWM_BITS = PWM_BITS_DEF,
  parameter int unsigned CODE_W   = CODE_W_DEF
) ();

  logic                beat_in;
  logic [CODE_W-1:0]   fault_code;
  logic [PWM_BITS-1:0] brightness;
  logic                led_out;
  logic                busy;
  logic                seq_start;

  modport master (
    output beat_in, fault_code, brightness,
    input  led_out, busy, seq_start
  );

  modport slave (
    input  beat_in, fault_code, brightness,
    output led_out, busy, seq_start
  );

endinterface

// File: rtl/led_pwm_gen.sv
// Free-running PWM counter; pwm_on is high while the count is below brightness.
module led_pwm_gen
  import led_status_pkg::*;
#(
  parameter int unsigned PWM_BITS = PWM_BITS_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PWM_BITS-1:0] brightness,
  output logic                pwm_on
);

  logic [PWM_BITS-1:0] pwm_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) pwm_cnt_q <= '0;
    else     pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
  end

  // Combinational compare so the registered LED stage sees live brightness.
  assign pwm_on = (pwm_cnt_q < brightness);

endmodule

// File: rtl/led_status_encoder.sv
// Heartbeat passthrough with blink-code fault override, all gated by PWM dimming.
module led_status_encoder
  import led_status_pkg::*;
#(
  parameter int unsigned PWM_BITS  = PWM_BITS_DEF,
  parameter int unsigned BLINK_DIV = BLINK_DIV_DEF,
  parameter int unsigned GAP_SLOTS = GAP_SLOTS_DEF,
  parameter int unsigned CODE_W    = CODE_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  led_status_encoder_if.slave  bus
);

  localparam int unsigned SLOT_W = $clog2(BLINK_DIV);
  localparam int unsigned GAP_W  = $clog2(GAP_SLOTS + 1);

  led_state_e        state_q, state_d;
  logic [SLOT_W-1:0] slot_cnt_q, slot_cnt_d, slot_cnt_adv;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [CODE_W-1:0] blinks_left_q, blinks_left_d;
  logic              led_q, led_d;
  logic              busy_q, busy_d;
  logic              seq_start_q, seq_start_d;
  logic              pwm_on;
  logic              slot_end;

  led_pwm_gen #(.PWM_BITS(PWM_BITS)) u_pwm (
    .clk        (clk),
    .rst        (rst),
    .brightness (bus.brightness),
    .pwm_on     (pwm_on)
  );

  assign slot_end     = (slot_cnt_q == SLOT_W'(BLINK_DIV - 1));
  assign slot_cnt_adv = slot_end ? '0 : slot_cnt_q + SLOT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      slot_cnt_q    <= '0;
      gap_cnt_q     <= '0;
      blinks_left_q <= '0;
      led_q         <= 1'b0;
      busy_q        <= 1'b0;
      seq_start_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      slot_cnt_q    <= slot_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      blinks_left_q <= blinks_left_d;
      led_q         <= led_d;
      busy_q        <= busy_d;
      seq_start_q   <= seq_start_d;
    end
  end

  // Slot counter idles at zero so each sequence starts on a fresh slot.
  always_comb begin
    state_d       = state_q;
    slot_cnt_d    = '0;
    gap_cnt_d     = gap_cnt_q;
    blinks_left_d = blinks_left_q;
    led_d         = 1'b0;
    seq_start_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        led_d = bus.beat_in & pwm_on;
        if (bus.fault_code != '0) begin
          blinks_left_d = bus.fault_code;
          seq_start_d   = 1'b1;
          state_d       = ST_ON;
        end
      end
      ST_ON: begin
        led_d      = pwm_on;
        slot_cnt_d = slot_cnt_adv;
        if (slot_end) state_d = ST_OFF;
      end
      ST_OFF: begin
        slot_cnt_d = slot_cnt_adv;
        if (slot_end) begin
          if (blinks_left_q == CODE_W'(1)) begin
            gap_cnt_d = '0;
            state_d   = ST_GAP;
          end else begin
            blinks_left_d = blinks_left_q - CODE_W'(1);
            state_d       = ST_ON;
          end
        end
      end
      ST_GAP: begin
        slot_cnt_d = slot_cnt_adv;
        if (slot_end) begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
          if (gap_cnt_q == GAP_W'(GAP_SLOTS - 1)) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign bus.led_out   = led_q;
  assign bus.busy      = busy_q;
  assign bus.seq_start = seq_start_q;

endmodule
